// File: rtl/huffman_pkg.sv
// Purpose: shared types, constants and symbol mapping for the Huffman stream decoder.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package huffman_pkg;

    localparam int TABLE_BASE   = 90;             // byte address of code table entry 0
    localparam int NUM_CHARS    = 45;             // symbols in the alphabet
    localparam int EOT_IDX      = 44;             // index of the end-of-text symbol
    localparam int MAX_CODE_LEN = 16;             // longest legal code in bits
    localparam int TABLE_BYTES  = 3 * NUM_CHARS;  // {len, path_hi, path_lo} per entry

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_RD,
        S_LD_CAP,
        S_FETCH,
        S_FETCH_CAP,
        S_SHIFT,
        S_MATCH,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

    // Symbol index to ASCII: a-z, 0-9, space . , ? ! ; : ' and EOT (0x04).
    function automatic logic [7:0] charlist(input logic [5:0] idx);
        logic [7:0] c;
        c = 8'h00;
        if (idx < 6'd26) begin
            c = 8'h61 + {2'b00, idx};
        end else if (idx < 6'd36) begin
            c = 8'h30 + ({2'b00, idx} - 8'd26);
        end else begin
            case (idx)
                6'd36:   c = 8'h20;
                6'd37:   c = 8'h2E;
                6'd38:   c = 8'h2C;
                6'd39:   c = 8'h3F;
                6'd40:   c = 8'h21;
                6'd41:   c = 8'h3B;
                6'd42:   c = 8'h3A;
                6'd43:   c = 8'h27;
                6'd44:   c = 8'h04;
                default: c = 8'h00;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Purpose: 45-way masked compare of the candidate code against the loaded table, lowest index wins.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
// Ports: tbl (raw table bytes), cand_path/cand_len (bits gathered so far) -> hit, idx (matching entry).
module huffman_code_match
    import huffman_pkg::*;
(
    input  logic [7:0]  tbl [TABLE_BYTES],
    input  logic [15:0] cand_path,
    input  logic [4:0]  cand_len,
    output logic        hit,
    output logic [5:0]  idx
);

    logic [15:0] mask;

    // Only the first cand_len path bits take part in the compare.
    assign mask = (cand_len >= 5'd16) ? 16'hFFFF : ((16'd1 << cand_len) - 16'd1);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_CHARS - 1; k >= 0; k--) begin
            if ((cand_len != 5'd0) &&
                (tbl[3*k] == {3'b000, cand_len}) &&
                (({tbl[3*k+1], tbl[3*k+2]} & mask) == cand_path)) begin
                hit = 1'b1;
                idx = 6'(k);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Purpose: loads the Huffman code table from memory, decodes the compressed stream bit by bit, writes ASCII out.
// Latency: 270-cycle table load, then 2 cycles per fetched byte, 2 per bit, 1 per emitted character.
// Backpressure: none; fixed one-cycle read latency on a shared single-port byte bus, read/write never together.
// Ports: clk, n_rst, dec_start in; data_read (memory data, valid the cycle after read) in;
//        dec_done, dec_error status out; read, write, addr, data memory bus out.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter logic [15:0] SRC_BASE = 16'd300,
    parameter logic [15:0] SRC_LEN  = 16'd256,
    parameter logic [15:0] DST_BASE = 16'd600,
    parameter logic [15:0] MAX_OUT  = 16'd1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        dec_start,
    input  logic [7:0]  data_read,
    output logic        dec_done,
    output logic        dec_error,
    output logic        read,
    output logic        write,
    output logic [15:0] addr,
    output logic [7:0]  data
);

    state_t      state_q, state_d;
    logic [7:0]  tbl_q [TABLE_BYTES];
    logic [7:0]  tidx_q;
    logic [15:0] src_ptr_q;
    logic [15:0] dst_ptr_q;
    logic [15:0] cand_path_q;
    logic [4:0]  cand_len_q;
    logic [7:0]  shreg_q;
    logic [3:0]  bit_cnt_q;
    logic        match_hit;
    logic [5:0]  match_idx;

    huffman_code_match u_match (
        .tbl       (tbl_q),
        .cand_path (cand_path_q),
        .cand_len  (cand_len_q),
        .hit       (match_hit),
        .idx       (match_idx)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus outputs. The candidate code is stable from MATCH
    // into EMIT, so the comparator output is still valid while emitting.
    always_comb begin
        state_d   = state_q;
        read      = 1'b0;
        write     = 1'b0;
        addr      = '0;
        data      = '0;
        dec_done  = 1'b0;
        dec_error = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dec_start) state_d = S_LD_RD;
            end
            S_LD_RD: begin
                read    = 1'b1;
                addr    = 16'(TABLE_BASE) + {8'd0, tidx_q};
                state_d = S_LD_CAP;
            end
            S_LD_CAP: begin
                state_d = (tidx_q == 8'(TABLE_BYTES - 1)) ? S_FETCH : S_LD_RD;
            end
            S_FETCH: begin
                if (src_ptr_q == SRC_LEN) begin
                    state_d = S_ERR;
                end else begin
                    read    = 1'b1;
                    addr    = SRC_BASE + src_ptr_q;
                    state_d = S_FETCH_CAP;
                end
            end
            S_FETCH_CAP: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                state_d = S_MATCH;
            end
            S_MATCH: begin
                if (match_hit)                              state_d = S_EMIT;
                else if (cand_len_q == 5'(MAX_CODE_LEN))    state_d = S_ERR;
                else if (bit_cnt_q == 4'd0)                 state_d = S_FETCH;
                else                                        state_d = S_SHIFT;
            end
            S_EMIT: begin
                write = 1'b1;
                addr  = DST_BASE + dst_ptr_q;
                data  = charlist(match_idx);
                if ((match_idx == 6'(EOT_IDX)) || (dst_ptr_q + 16'd1 == MAX_OUT))
                    state_d = S_DONE;
                else if (bit_cnt_q == 4'd0)
                    state_d = S_FETCH;
                else
                    state_d = S_SHIFT;
            end
            S_DONE: begin
                dec_done = 1'b1;
                if (!dec_start) state_d = S_IDLE;
            end
            S_ERR: begin
                dec_done  = 1'b1;
                dec_error = 1'b1;
                if (!dec_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < TABLE_BYTES; i++) tbl_q[i] <= '0;
        end else if (state_q == S_LD_CAP) begin
            tbl_q[tidx_q] <= data_read;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tidx_q      <= '0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            cand_path_q <= '0;
            cand_len_q  <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dec_start) begin
                        tidx_q      <= '0;
                        src_ptr_q   <= '0;
                        dst_ptr_q   <= '0;
                        // A previous run may have stopped mid-code.
                        cand_path_q <= '0;
                        cand_len_q  <= '0;
                    end
                end
                S_LD_CAP: begin
                    tidx_q <= tidx_q + 8'd1;
                end
                S_FETCH_CAP: begin
                    shreg_q   <= data_read;
                    bit_cnt_q <= 4'd8;
                    src_ptr_q <= src_ptr_q + 16'd1;
                end
                S_SHIFT: begin
                    // cand_len is at most 15 here; MATCH stops the run at 16.
                    cand_path_q[cand_len_q[3:0]] <= shreg_q[7];
                    shreg_q    <= {shreg_q[6:0], 1'b0};
                    bit_cnt_q  <= bit_cnt_q - 4'd1;
                    cand_len_q <= cand_len_q + 5'd1;
                end
                S_EMIT: begin
                    dst_ptr_q   <= dst_ptr_q + 16'd1;
                    cand_path_q <= '0;
                    cand_len_q  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Purpose: self-checking bench for huffman_decoder; two instances (full and one-byte source window) share one memory image.
// Latency: n/a.
// Backpressure: n/a.
module tb_huffman_decoder;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        dec_start = 1'b0;
    logic [7:0]  data_read [2];
    logic [1:0]  dec_done, dec_error, rd, wr;
    logic [15:0] addr [2];
    logic [7:0]  wdata [2];
    logic [7:0]  img [0:65535];
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        huffman_decoder #(.SRC_LEN(gi == 0 ? 16'd256 : 16'd1)) u_dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .dec_start (dec_start),
            .data_read (data_read[gi]),
            .dec_done  (dec_done[gi]),
            .dec_error (dec_error[gi]),
            .read      (rd[gi]),
            .write     (wr[gi]),
            .addr      (addr[gi]),
            .data      (wdata[gi])
        );
    end

    // Memory: read data returns one cycle after the address is presented.
    always @(posedge clk) for (int i = 0; i < 2; i++) data_read[i] <= img[addr[i]];

    // Bus monitor, sampled on the falling edge.
    bit          mon_en = 1'b0;
    int          ld_cnt [2], ld_bad [2], last_rd [2], src_cnt [2], src_bad [2];
    int          excl_bad [2], wcnt [2], done_cyc [2];
    logic        done_err [2];
    logic [15:0] wa [2][1024];
    logic [7:0]  wd [2][1024];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!mon_en) begin
                ld_cnt[i] = 0; ld_bad[i] = 0; last_rd[i] = 0; src_cnt[i] = 0; src_bad[i] = 0;
                excl_bad[i] = 0; wcnt[i] = 0; done_cyc[i] = -1; done_err[i] = 1'b0;
            end else begin
                if (rd[i] && wr[i]) excl_bad[i]++;
                if (rd[i]) begin
                    if (ld_cnt[i] < 135) begin
                        if (addr[i] != 16'(90 + ld_cnt[i])) ld_bad[i]++;
                        if (ld_cnt[i] > 0 && cyc - last_rd[i] != 2) ld_bad[i]++;
                        last_rd[i] = cyc;
                        ld_cnt[i]++;
                    end else begin
                        if (addr[i] != 16'(300 + src_cnt[i])) src_bad[i]++;
                        src_cnt[i]++;
                    end
                end
                if (wr[i] && wcnt[i] < 1024) begin
                    wa[i][wcnt[i]] = addr[i];
                    wd[i][wcnt[i]] = wdata[i];
                    wcnt[i]++;
                end
                if (dec_done[i] && done_cyc[i] < 0) begin
                    done_cyc[i] = cyc;
                    done_err[i] = dec_error[i];
                end
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: code table as (len, path) per symbol, decoded at symbol level.
    string       alphabet = "abcdefghijklmnopqrstuvwxyz0123456789 .,?!;:'";
    int          t_len [45], t_path [45];
    logic [15:0] m_wa [2][1024];
    logic [7:0]  m_wd [2][1024];
    int          m_wcnt [2], m_src [2], m_cyc [2];
    logic        m_err [2];

    function automatic logic [7:0] chr(input int k);
        return (k == 44) ? 8'h04 : alphabet[k];
    endfunction

    task automatic run_model(input int i, input int src_len);
        int ptr, nleft, clen, code, nbits, nemit, extra, hitk;
        logic [7:0] cur;
        ptr = 0; nleft = 0; clen = 0; code = 0; nbits = 0; nemit = 0; extra = 0;
        cur = 8'h00; m_wcnt[i] = 0; m_err[i] = 1'b0;
        forever begin
            if (nleft == 0) begin
                if (ptr == src_len) begin extra = 1; m_err[i] = 1'b1; break; end
                cur = img[300 + ptr]; ptr++; nleft = 8;
            end
            if (cur[7]) code = code | (1 << clen);
            cur = cur << 1; nleft--; clen++; nbits++;
            hitk = -1;
            for (int k = 0; k < 45 && hitk < 0; k++)
                if (t_len[k] == clen && (t_path[k] & ((1 << clen) - 1)) == code) hitk = k;
            if (hitk >= 0) begin
                m_wa[i][m_wcnt[i]] = 16'(600 + nemit);
                m_wd[i][m_wcnt[i]] = chr(hitk);
                m_wcnt[i]++; nemit++;
                code = 0; clen = 0;
                if (hitk == 44 || nemit == 1024) break;
            end else if (clen == 16) begin
                m_err[i] = 1'b1; break;
            end
        end
        m_src[i] = ptr;
        m_cyc[i] = 270 + 2 * ptr + 2 * nbits + nemit + extra;
    endtask

    task automatic clear_table();
        for (int k = 0; k < 45; k++) begin t_len[k] = 0; t_path[k] = 0; end
    endtask

    task automatic write_table();
        for (int k = 0; k < 45; k++) begin
            img[90 + 3*k] = 8'(t_len[k]);
            img[91 + 3*k] = 8'(t_path[k] >> 8);
            img[92 + 3*k] = 8'(t_path[k]);
        end
        for (int a = 0; a < 256; a++) img[300 + a] = 8'h00;
    endtask

    task automatic set_t1();
        clear_table();
        t_len[0] = 1;  t_path[0] = 1;
        t_len[1] = 2;  t_path[1] = 2;
        t_len[44] = 2; t_path[44] = 0;
        write_table();
    endtask

    task automatic run_test(input string name);
        int start_cyc, n;
        run_model(0, 256);
        run_model(1, 1);
        mon_en = 1'b0; dec_start = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1; dec_start = 1'b1; start_cyc = cyc;
        n = 0;
        // Random start noise while decoding; held high once any instance finishes.
        while (dec_done != 2'b11 && n < 20000) begin
            @(negedge clk); n++;
            if (dec_done != 2'b00) dec_start = 1'b1;
            else dec_start = 1'($urandom_range(0, 1));
        end
        chk($sformatf("%s/timeout", name), 32'(n < 20000), 32'd1);
        dec_start = 1'b0;
        repeat (3) @(negedge clk);
        chk($sformatf("%s/back_to_idle", name), {30'd0, dec_done}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s/d%0d/error", name, i), {31'd0, done_err[i]}, {31'd0, m_err[i]});
            chk($sformatf("%s/d%0d/cycles", name, i), done_cyc[i] - start_cyc - 1, m_cyc[i]);
            chk($sformatf("%s/d%0d/load_reads", name, i), ld_cnt[i], 135);
            chk($sformatf("%s/d%0d/load_seq", name, i), ld_bad[i], 0);
            chk($sformatf("%s/d%0d/rd_wr_excl", name, i), excl_bad[i], 0);
            chk($sformatf("%s/d%0d/src_reads", name, i), src_cnt[i], m_src[i]);
            chk($sformatf("%s/d%0d/src_addr", name, i), src_bad[i], 0);
            chk($sformatf("%s/d%0d/wr_count", name, i), wcnt[i], m_wcnt[i]);
            for (int j = 0; j < m_wcnt[i] && j < wcnt[i]; j++) begin
                chk($sformatf("%s/d%0d/wr%0d_addr", name, i, j), {16'd0, wa[i][j]}, {16'd0, m_wa[i][j]});
                chk($sformatf("%s/d%0d/wr%0d_data", name, i, j), {24'd0, wd[i][j]}, {24'd0, m_wd[i][j]});
            end
        end
    endtask

    task automatic reset_mid();
        int n;
        set_t1();
        img[300] = 8'h55; img[301] = 8'h00;
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1; dec_start = 1'b1;
        n = 0;
        while (!(rd[0] && addr[0] == 16'd300) && n < 1000) begin @(negedge clk); n++; end
        chk("rst/reach_fetch", 32'(n < 1000), 32'd1);
        dec_start = 1'b0;
        @(posedge clk); @(posedge clk); #1;     // FETCH -> FETCH_CAP -> SHIFT
        n_rst = 1'b0;
        #1;
        chk("rst/strobes", {28'd0, rd, wr}, 32'd0);
        chk("rst/status", {28'd0, dec_done, dec_error}, 32'd0);
        chk("rst/addr", {addr[0], addr[1]}, 32'd0);
        chk("rst/wdata", {16'd0, wdata[0], wdata[1]}, 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst/idle_quiet", {26'd0, rd, wr, dec_done}, 32'd0);
    endtask

    task automatic rand_setup();
        int  lens [12], paths [12], syms [12];
        int  nl, target, j, eot_leaf, s, nsym;
        bit  used [45];
        bit  bq [$];
        clear_table();
        for (int k = 0; k < 45; k++) used[k] = 1'b0;
        // Grow a random complete prefix tree by splitting leaves.
        nl = 1; lens[0] = 0; paths[0] = 0;
        target = $urandom_range(2, 12);
        while (nl < target) begin
            j = $urandom_range(0, nl - 1);
            if (lens[j] < 10) begin
                lens[nl] = lens[j] + 1; paths[nl] = paths[j];
                paths[j] = paths[j] | (1 << lens[j]);
                lens[j]++;
                nl++;
            end
        end
        eot_leaf = $urandom_range(0, nl - 1);
        for (int l = 0; l < nl; l++) begin
            if (l == eot_leaf) s = 44;
            else begin
                s = $urandom_range(0, 43);
                while (used[s]) s = $urandom_range(0, 43);
            end
            used[s] = 1'b1; syms[l] = s;
            t_len[s] = lens[l]; t_path[s] = paths[l];
        end
        // Sometimes knock out a code, or give it a second owner to exercise priority.
        j = (eot_leaf + 1) % nl;
        if ($urandom_range(0, 3) == 0) t_len[syms[j]] = 0;
        else if ($urandom_range(0, 2) == 0) begin
            s = $urandom_range(0, 43);
            while (used[s]) s = $urandom_range(0, 43);
            t_len[s] = lens[j]; t_path[s] = paths[j];
        end
        write_table();
        for (int a = 0; a < 256; a++) img[300 + a] = 8'($urandom);
        nsym = $urandom_range(0, 15);
        for (int c = 0; c <= nsym; c++) begin
            if (c == nsym) j = eot_leaf;
            else begin
                j = $urandom_range(0, nl - 1);
                while (j == eot_leaf) j = $urandom_range(0, nl - 1);
            end
            for (int b = 0; b < lens[j]; b++) bq.push_back(paths[j][b]);
        end
        for (int b = 0; b < bq.size(); b++) img[300 + b/8][7 - (b % 8)] = bq[b];
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) img[a] = 8'h00;
        #1;
        chk("reset/strobes", {28'd0, rd, wr}, 32'd0);
        chk("reset/status", {28'd0, dec_done, dec_error}, 32'd0);
        chk("reset/addr", {addr[0], addr[1]}, 32'd0);
        chk("reset/wdata", {16'd0, wdata[0], wdata[1]}, 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        set_t1(); img[300] = 8'hA0;
        run_test("abeot");
        set_t1(); img[300] = 8'h55; img[301] = 8'h00;
        run_test("straddle");
        clear_table(); t_len[44] = 1; t_path[44] = 1; write_table();
        run_test("nomatch16");
        set_t1(); img[300] = 8'hFF; img[301] = 8'h00;
        run_test("src_exhaust");
        set_t1(); img[300] = 8'h80;
        run_test("a_then_eot");

        reset_mid();
        set_t1(); img[300] = 8'hA0;
        run_test("after_reset");

        for (int r = 0; r < 20; r++) begin
            rand_setup();
            run_test($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
